axis_golden_checker: RTL and testbench

Parametrised self-test checker: joins a DUT AXI-stream output with a golden-reference stream (typically an `axis_rom_fifo`) beat by beat. It compares data and checks TLAST placement against a configured beat count. It also watches for stalls with a timeout. Sits at the top of FPGA self-test wrappers in place of ad-hoc compare logic, and reports detailed failure diagnostics instead of a single fail bit.

---
 rtl/axis_checker_pkg.sv | 18 +
 rtl/stall_watchdog.sv | 31 +++
 rtl/axis_golden_checker.sv | 147 ++++++++++++++
 tb/tb_axis_golden_checker.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_checker_pkg.sv
// Shared types for the AXI-stream golden checker: FSM states and fail-reason bit map.
// No logic, so no latency.
// No flow control of its own.
package axis_checker_pkg;

    localparam int FAIL_REASON_W   = 4;
    localparam int FR_MISMATCH     = 0;
    localparam int FR_LAST_EARLY   = 1;
    localparam int FR_LAST_MISSING = 2;
    localparam int FR_TIMEOUT      = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/stall_watchdog.sv
// Counts enabled cycles since the last clear and flags when the stall reaches the limit.
// Latency: expired is combinational on the edge that completes the limit-th stall cycle.
// Backpressure: none; a zero limit disables expiry.
module stall_watchdog #(
    parameter int TIMEOUT_WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [TIMEOUT_WIDTH-1:0] limit,
    output logic                     expired
);

    logic [TIMEOUT_WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + TIMEOUT_WIDTH'(1);
        end
    end

    // Fires on the edge that would make the stall count equal to the limit.
    assign expired = enable & ~clear & (limit != '0) &
                     (r_count == limit - TIMEOUT_WIDTH'(1));

endmodule

// File: rtl/axis_golden_checker.sv
// Joins a DUT stream with a golden stream, compares beats, checks TLAST placement and stalls.
// Latency: status registered one cycle after the deciding fire/timeout edge.
// Backpressure: each stream is accepted only when the other is valid; both readies low outside RUN.
module axis_golden_checker
    import axis_checker_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int COUNT_WIDTH   = 32,
    parameter int TIMEOUT_WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [COUNT_WIDTH-1:0]   cfg_expected_beats,
    input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout,
    input  logic [DATA_WIDTH-1:0]    axis_dut_data,
    input  logic                     axis_dut_valid,
    input  logic                     axis_dut_last,
    output logic                     axis_dut_ready,
    input  logic [DATA_WIDTH-1:0]    axis_gold_data,
    input  logic                     axis_gold_valid,
    output logic                     axis_gold_ready,
    output logic                     busy,
    output logic                     finished,
    output logic                     failed,
    output logic [FAIL_REASON_W-1:0] fail_reason,
    output logic [COUNT_WIDTH-1:0]   beat_count,
    output logic [COUNT_WIDTH-1:0]   mismatch_count,
    output logic [COUNT_WIDTH-1:0]   first_mismatch_index,
    output logic [DATA_WIDTH-1:0]    first_mismatch_dut,
    output logic [DATA_WIDTH-1:0]    first_mismatch_gold
);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [COUNT_WIDTH-1:0]   r_exp_beats;
    logic [TIMEOUT_WIDTH-1:0] r_timeout;
    logic [COUNT_WIDTH-1:0]   r_beat_count;
    logic [COUNT_WIDTH-1:0]   r_mismatch_count;
    logic [COUNT_WIDTH-1:0]   r_first_idx;
    logic [DATA_WIDTH-1:0]    r_first_dut;
    logic [DATA_WIDTH-1:0]    r_first_gold;
    logic [FAIL_REASON_W-1:0] r_fail_reason;
    logic [FAIL_REASON_W-1:0] w_fail_set;

    logic w_run;
    logic w_start_acc;
    logic w_fire;
    logic w_final;
    logic w_data_ne;
    logic w_expired;
    logic w_end;

    assign w_run       = (r_state == ST_RUN);
    assign w_start_acc = start & ~w_run & (cfg_expected_beats != '0);
    assign w_fire      = w_run & axis_dut_valid & axis_gold_valid;
    assign w_final     = (r_beat_count == r_exp_beats - COUNT_WIDTH'(1));
    assign w_data_ne   = (axis_dut_data != axis_gold_data);
    assign w_end       = (w_fire & (w_final | axis_dut_last)) | w_expired;

    stall_watchdog #(
        .TIMEOUT_WIDTH(TIMEOUT_WIDTH)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .enable (w_run),
        .clear  (w_start_acc | w_fire),
        .limit  (r_timeout),
        .expired(w_expired)
    );

    always_comb begin
        w_fail_set                  = '0;
        w_fail_set[FR_MISMATCH]     = w_fire & w_data_ne;
        w_fail_set[FR_LAST_EARLY]   = w_fire & axis_dut_last & ~w_final;
        w_fail_set[FR_LAST_MISSING] = w_fire & ~axis_dut_last & w_final;
        w_fail_set[FR_TIMEOUT]      = w_expired;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (w_start_acc) w_state_nxt = ST_RUN;
            ST_RUN:           if (w_end)       w_state_nxt = ST_DONE;
            default:          w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_exp_beats      <= '0;
            r_timeout        <= '0;
            r_beat_count     <= '0;
            r_mismatch_count <= '0;
            r_first_idx      <= '0;
            r_first_dut      <= '0;
            r_first_gold     <= '0;
            r_fail_reason    <= '0;
        end else if (w_start_acc) begin
            r_exp_beats      <= cfg_expected_beats;
            r_timeout        <= cfg_timeout;
            r_beat_count     <= '0;
            r_mismatch_count <= '0;
            r_first_idx      <= '0;
            r_first_dut      <= '0;
            r_first_gold     <= '0;
            r_fail_reason    <= '0;
        end else if (w_run) begin
            r_fail_reason <= r_fail_reason | w_fail_set;
            if (w_fire) begin
                r_beat_count <= r_beat_count + COUNT_WIDTH'(1);
                if (w_data_ne) begin
                    // A zero count means no earlier mismatch this run (it saturates, never wraps).
                    if (r_mismatch_count == '0) begin
                        r_first_idx  <= r_beat_count;
                        r_first_dut  <= axis_dut_data;
                        r_first_gold <= axis_gold_data;
                    end
                    if (r_mismatch_count != '1) begin
                        r_mismatch_count <= r_mismatch_count + COUNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    assign axis_dut_ready       = w_run & axis_gold_valid;
    assign axis_gold_ready      = w_run & axis_dut_valid;
    assign busy                 = w_run;
    assign finished             = (r_state == ST_DONE);
    assign failed               = |r_fail_reason;
    assign fail_reason          = r_fail_reason;
    assign beat_count           = r_beat_count;
    assign mismatch_count       = r_mismatch_count;
    assign first_mismatch_index = r_first_idx;
    assign first_mismatch_dut   = r_first_dut;
    assign first_mismatch_gold  = r_first_gold;

endmodule

// File: tb/tb_axis_golden_checker.sv
// Bench for axis_golden_checker: randomized streams against a beat-level reference model.
module tb_axis_golden_checker;

    localparam int DW = 64;
    localparam int CW = 32;
    localparam int TW = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] cfg_expected_beats = '0;
    logic [TW-1:0] cfg_timeout = '0;
    logic [DW-1:0] dut_data = '0;
    logic          dut_valid = 1'b0;
    logic          dut_last = 1'b0;
    logic          dut_ready;
    logic [DW-1:0] gold_data = '0;
    logic          gold_valid = 1'b0;
    logic          gold_ready;
    logic          busy, finished, failed;
    logic [3:0]    fail_reason;
    logic [CW-1:0] beat_count, mismatch_count, first_idx;
    logic [DW-1:0] first_dut, first_gold;

    axis_golden_checker #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .TIMEOUT_WIDTH(TW)) dut (
        .clk                 (clk),
        .rst                 (rst_n),
        .start               (start),
        .cfg_expected_beats  (cfg_expected_beats),
        .cfg_timeout         (cfg_timeout),
        .axis_dut_data       (dut_data),
        .axis_dut_valid      (dut_valid),
        .axis_dut_last       (dut_last),
        .axis_dut_ready      (dut_ready),
        .axis_gold_data      (gold_data),
        .axis_gold_valid     (gold_valid),
        .axis_gold_ready     (gold_ready),
        .busy                (busy),
        .finished            (finished),
        .failed              (failed),
        .fail_reason         (fail_reason),
        .beat_count          (beat_count),
        .mismatch_count      (mismatch_count),
        .first_mismatch_index(first_idx),
        .first_mismatch_dut  (first_dut),
        .first_mismatch_gold (first_gold)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] s_dut[64];
    logic [DW-1:0] s_gold[64];
    int            s_last_at;
    int            last_fire_cyc, fin_cyc;

    // Reference model: one beat-level transaction view of a run.
    bit            m_running, m_done, m_ok, m_stop;
    int            m_beats, m_exp, m_tmo, m_stall, m_i;
    logic [CW-1:0] m_mism, m_fidx;
    logic [DW-1:0] m_fd, m_fg;
    logic [3:0]    m_reason;

    task automatic m_clear();
        m_beats = 0; m_mism = '0; m_fidx = '0; m_fd = '0; m_fg = '0;
        m_reason = '0; m_stall = 0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            m_running = 0; m_done = 0; m_exp = 0; m_tmo = 0;
            m_clear();
        end
        m_ok = (busy === m_running) && (finished === m_done) &&
               (fail_reason === m_reason) && (failed === (|m_reason)) &&
               (beat_count === CW'(m_beats)) && (mismatch_count === m_mism) &&
               (first_idx === m_fidx) && (first_dut === m_fd) && (first_gold === m_fg) &&
               (dut_ready === (m_running & gold_valid)) && (gold_ready === (m_running & dut_valid));
        checks++;
        if (!m_ok) begin
            errors++;
            $display("FAIL model_cycle t=%0t busy=%b/%b fin=%b/%b reason=%b/%b beats=%0d/%0d mism=%0d/%0d idx=%0d/%0d rdy=%b%b/%b%b cap=%h,%h/%h,%h",
                     $time, busy, m_running, finished, m_done, fail_reason, m_reason,
                     beat_count, m_beats, mismatch_count, m_mism, first_idx, m_fidx,
                     dut_ready, gold_ready, m_running & gold_valid, m_running & dut_valid,
                     first_dut, first_gold, m_fd, m_fg);
        end
        if (rst_n) begin
            m_stop = 0;
            if (start && cfg_expected_beats != 0 && !m_running) begin
                m_running = 1; m_done = 0;
                m_exp = int'(cfg_expected_beats); m_tmo = int'(cfg_timeout);
                m_clear();
            end else if (m_running) begin
                if (dut_valid && gold_valid) begin
                    m_i = m_beats;
                    m_beats++;
                    m_stall = 0;
                    if (dut_data != gold_data) begin
                        if (m_mism == 0) begin
                            m_fidx = CW'(m_i); m_fd = dut_data; m_fg = gold_data;
                        end
                        if (m_mism != '1) m_mism = m_mism + 1;
                        m_reason[0] = 1'b1;
                    end
                    if (m_i == m_exp - 1) begin
                        if (!dut_last) m_reason[2] = 1'b1;
                        m_stop = 1;
                    end else if (dut_last) begin
                        m_reason[1] = 1'b1;
                        m_stop = 1;
                    end
                end else begin
                    m_stall++;
                    if (m_tmo != 0 && m_stall == m_tmo) begin
                        m_reason[3] = 1'b1;
                        m_stop = 1;
                    end
                end
                if (m_stop) begin
                    m_running = 0; m_done = 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic gen(input int corrupt_pct, input int last_at);
        for (int i = 0; i < 64; i++) begin
            s_gold[i] = {$urandom, $urandom};
            s_dut[i]  = s_gold[i];
            if ($urandom_range(0, 99) < corrupt_pct) s_dut[i] = s_dut[i] ^ ({$urandom, $urandom} | 64'h1);
        end
        s_last_at = last_at;
    endtask

    // Drives one run; stops when finished is seen, after stop_at fires, or on budget expiry.
    task automatic do_run(input int exp, input int tmo, input int avail, input int gmax,
                          input int stall_after, input int stop_at);
        int  k, gd, gg;
        bit  f, seen;
        cfg_expected_beats = CW'(exp);
        cfg_timeout        = TW'(tmo);
        start              = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0; seen = 0;
        gd = $urandom_range(0, gmax);
        gg = $urandom_range(0, gmax);
        for (int c = 0; c < 600; c++) begin
            dut_valid  = (k < avail) && (gd == 0);
            dut_data   = s_dut[k];
            dut_last   = (k == s_last_at);
            gold_valid = (k < avail) && (gg == 0) && (k < stall_after);
            gold_data  = s_gold[k];
            @(negedge clk);
            if (finished) begin
                seen = 1; fin_cyc = cyc;
                break;
            end
            f = dut_valid && dut_ready && gold_valid && gold_ready;
            @(posedge clk); #1;
            if (f) begin
                k++;
                last_fire_cyc = cyc;
                gd = $urandom_range(0, gmax);
                gg = $urandom_range(0, gmax);
                if (k == stop_at) break;
            end else begin
                if (gd > 0) gd--;
                if (gg > 0) gg--;
            end
        end
        dut_valid = 1'b0; gold_valid = 1'b0; dut_last = 1'b0;
        checks++;
        if (!(seen || k == stop_at)) begin
            errors++;
            $display("FAIL run_budget: run exp=%0d did not finish, beats fired %0d", exp, k);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        int e, t, la, sel, sa;
        repeat (3) @(posedge clk);
        #1;
        dut_valid = 1'b1; gold_valid = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_finished", finished, 0);
        chk("reset_failed", failed, 0);
        chk("reset_beat_count", beat_count, 0);
        chk("reset_dut_ready", dut_ready, 0);
        chk("reset_gold_ready", gold_ready, 0);
        dut_valid = 1'b0; gold_valid = 1'b0;

        // start with zero expected beats must be ignored
        @(posedge clk); #1;
        cfg_expected_beats = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("zero_beats_ignored_busy", busy, 0);

        // clean 8-beat run
        gen(0, 7);
        do_run(8, 0, 8, 3, 100, 1000);
        chk("t1_finished", finished, 1);
        chk("t1_failed", failed, 0);
        chk("t1_beat_count", beat_count, 8);
        chk("t1_mismatch_count", mismatch_count, 0);

        // beats 2 and 5 corrupted
        gen(0, 7);
        s_gold[2] = 64'hBEEF; s_dut[2] = 64'hDEAD;
        s_dut[5]  = s_gold[5] ^ 64'h10;
        do_run(8, 0, 8, 2, 100, 1000);
        chk("t2_fail_reason", fail_reason, 4'b0001);
        chk("t2_mismatch_count", mismatch_count, 2);
        chk("t2_first_index", first_idx, 2);
        chk("t2_first_dut", first_dut, 64'hDEAD);
        chk("t2_first_gold", first_gold, 64'hBEEF);
        chk("t2_beat_count", beat_count, 8);

        // TLAST early on beat 4
        gen(0, 4);
        do_run(8, 0, 8, 2, 100, 1000);
        chk("t3_fail_reason", fail_reason, 4'b0010);
        chk("t3_beat_count", beat_count, 5);

        // TLAST missing on final beat 3; extra beats must not be accepted
        gen(0, 100);
        do_run(4, 0, 8, 1, 100, 1000);
        chk("t4_fail_reason", fail_reason, 4'b0100);
        chk("t4_beat_count", beat_count, 4);
        dut_valid = 1'b1; gold_valid = 1'b1; dut_data = s_dut[4]; gold_data = s_gold[4];
        #1;
        chk("t4_dut_ready_after", dut_ready, 0);
        chk("t4_gold_ready_after", gold_ready, 0);
        @(posedge clk); #1;
        dut_valid = 1'b0; gold_valid = 1'b0;

        // gold stalls after beat 3 with timeout 10
        gen(0, 7);
        do_run(8, 10, 8, 0, 4, 1000);
        chk("t5_fail_reason", fail_reason, 4'b1000);
        chk("t5_beat_count", beat_count, 4);
        chk("t5_timeout_delay", 64'(fin_cyc - last_fire_cyc), 10);

        // gaps up to 8 stall cycles stay under a timeout of 10
        gen(0, 11);
        do_run(12, 10, 12, 8, 100, 1000);
        chk("t6_fail_reason", fail_reason, 4'b0000);
        chk("t6_beat_count", beat_count, 12);

        // asynchronous reset after beat 3, then a fresh passing run
        gen(0, 7);
        do_run(8, 0, 8, 1, 100, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_reset_busy", busy, 0);
        chk("t7_reset_finished", finished, 0);
        chk("t7_reset_beat_count", beat_count, 0);
        chk("t7_reset_fail_reason", fail_reason, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t7_after_reset_beat_count", beat_count, 0);
        gen(0, 7);
        do_run(8, 0, 8, 2, 100, 1000);
        chk("t7_rerun_failed", failed, 0);
        chk("t7_rerun_beat_count", beat_count, 8);

        // random runs checked by the model
        for (int r = 0; r < 30; r++) begin
            e   = $urandom_range(1, 12);
            t   = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(2, 12);
            sel = $urandom_range(0, 3);
            la  = (sel < 2) ? e - 1 : (sel == 2) ? $urandom_range(0, e - 1) : 100;
            sa  = (t != 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, e) : 100;
            gen(25, la);
            @(posedge clk); #1;
            do_run(e, t, 16, $urandom_range(0, 4), sa, 1000);
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
